// File: rtl/cordic_bus_slave.sv
// rtl/cordic_bus_slave.sv - APB-style register slave for a CORDIC controller
// Optional sticky IRQ latch enabled by defining CORDIC_BUS_IRQ_LATCH_EN.
module cordic_bus_slave #(
  parameter int p_WIDTH      = 32,
  parameter int p_ADDR_WIDTH = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [p_ADDR_WIDTH-1:0] paddr,
  input  logic [p_WIDTH-1:0]      pwdata,
  output logic [p_WIDTH-1:0]      prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [p_WIDTH-1:0]      xInput,
  output logic [p_WIDTH-1:0]      yInput,
  output logic [p_WIDTH-1:0]      zInput,
  output logic [p_WIDTH-1:0]      controlRegisterInput,
  input  logic [p_WIDTH-1:0]      xResult,
  input  logic [p_WIDTH-1:0]      yResult,
  input  logic [p_WIDTH-1:0]      zResult,
  input  logic [p_WIDTH-1:0]      controlRegisterOutput,
  input  logic                    controlRegisterWriteEnable,
  input  logic                    interrupt,
  output logic                    irq
);

  localparam logic [p_ADDR_WIDTH-1:0] L_ADDR_X    = p_ADDR_WIDTH'(5'h00);
  localparam logic [p_ADDR_WIDTH-1:0] L_ADDR_Y    = p_ADDR_WIDTH'(5'h04);
  localparam logic [p_ADDR_WIDTH-1:0] L_ADDR_Z    = p_ADDR_WIDTH'(5'h08);
  localparam logic [p_ADDR_WIDTH-1:0] L_ADDR_CTRL = p_ADDR_WIDTH'(5'h0C);
  localparam logic [p_ADDR_WIDTH-1:0] L_ADDR_IRQ  = p_ADDR_WIDTH'(5'h10);
  localparam logic [p_WIDTH-1:0]      L_CTRL_RST  = p_WIDTH'(32'h0001_0000);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic                      w_commit;
  logic                      w_addr_err;
  logic [p_ADDR_WIDTH-1:0]   r_addr;
  logic                      r_write;
  logic [p_WIDTH-1:0]        r_wdata;
  logic                      r_err;
  logic                      w_wr;
  logic                      w_rd;
  logic [p_WIDTH-1:0]        w_rdata;
  logic [p_WIDTH-1:0]        r_x;
  logic [p_WIDTH-1:0]        r_y;
  logic [p_WIDTH-1:0]        r_z;
  logic [p_WIDTH-1:0]        r_ctrl;
  logic [p_WIDTH-1:0]        r_prdata;
  logic                      r_int_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_state <= S_IDLE;
    else      r_state <= w_next;
  end

  // A transfer cannot start from DONE; it must pass through IDLE first.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (psel && penable) w_next = S_WAIT;
      S_WAIT:  w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_comb begin
    pready   = (r_state == S_DONE);
    pslverr  = (r_state == S_DONE) && r_err;
    w_commit = (r_state == S_WAIT);
  end

`ifdef CORDIC_BUS_IRQ_LATCH_EN
  assign w_addr_err = (paddr[1:0] != 2'b00) || (paddr > L_ADDR_IRQ);
`else
  assign w_addr_err = (paddr[1:0] != 2'b00) || (paddr >= L_ADDR_IRQ);
`endif

  // Request is captured at start so a mid-transfer psel drop still completes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_addr  <= '0;
      r_write <= 1'b0;
      r_wdata <= '0;
      r_err   <= 1'b0;
    end else if (r_state == S_IDLE && psel && penable) begin
      r_addr  <= paddr;
      r_write <= pwrite;
      r_wdata <= pwdata;
      r_err   <= w_addr_err;
    end
  end

  assign w_wr = w_commit && r_write && !r_err;
  assign w_rd = w_commit && !r_write;

`ifdef CORDIC_BUS_IRQ_LATCH_EN
  logic r_pend;
  logic w_clr;
  assign w_clr = w_wr && (r_addr == L_ADDR_IRQ) && r_wdata[0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_pend <= 1'b0;
    else      r_pend <= (interrupt && !r_int_d) || (r_pend && !w_clr);
  end

  assign irq = r_pend;
`else
  assign irq = r_int_d;
`endif

  always_comb begin
    w_rdata = '0;
    if (!r_err) begin
      case (r_addr)
        L_ADDR_X:    w_rdata = xResult;
        L_ADDR_Y:    w_rdata = yResult;
        L_ADDR_Z:    w_rdata = zResult;
        L_ADDR_CTRL: w_rdata = r_ctrl;
`ifdef CORDIC_BUS_IRQ_LATCH_EN
        L_ADDR_IRQ:  w_rdata = p_WIDTH'(r_pend);
`endif
        default:     w_rdata = '0;
      endcase
    end
  end

  // Controller write-back loads everything; a simultaneous bus write then overrides the low half.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_x      <= '0;
      r_y      <= '0;
      r_z      <= '0;
      r_ctrl   <= L_CTRL_RST;
      r_prdata <= '0;
      r_int_d  <= 1'b0;
    end else begin
      r_int_d <= interrupt;
      if (controlRegisterWriteEnable) r_ctrl <= controlRegisterOutput;
      if (w_wr) begin
        case (r_addr)
          L_ADDR_X:    r_x <= r_wdata;
          L_ADDR_Y:    r_y <= r_wdata;
          L_ADDR_Z:    r_z <= r_wdata;
          L_ADDR_CTRL: r_ctrl[15:0] <= r_wdata[15:0];
          default:     ;
        endcase
      end
      if (w_rd) r_prdata <= w_rdata;
    end
  end

  assign prdata               = r_prdata;
  assign xInput               = r_x;
  assign yInput               = r_y;
  assign zInput               = r_z;
  assign controlRegisterInput = r_ctrl;

endmodule

// File: tb/tb_cordic_bus_slave.sv
// tb/tb_cordic_bus_slave.sv - self-checking bench for cordic_bus_slave
module tb_cordic_bus_slave;

`ifdef CORDIC_BUS_IRQ_LATCH_EN
  localparam bit LATCH = 1'b1;
`else
  localparam bit LATCH = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [4:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] xInput, yInput, zInput, controlRegisterInput;
  logic [31:0] xResult = '0, yResult = '0, zResult = '0, controlRegisterOutput = '0;
  logic        controlRegisterWriteEnable = 1'b0;
  logic        interrupt = 1'b0;
  logic        irq;

  cordic_bus_slave #(.p_WIDTH(32), .p_ADDR_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr),
    .xInput(xInput), .yInput(yInput), .zInput(zInput),
    .controlRegisterInput(controlRegisterInput),
    .xResult(xResult), .yResult(yResult), .zResult(zResult),
    .controlRegisterOutput(controlRegisterOutput),
    .controlRegisterWriteEnable(controlRegisterWriteEnable),
    .interrupt(interrupt), .irq(irq)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  // Reference register file: what the host should see after each transfer.
  logic [31:0] m_x, m_y, m_z, m_ctrl, m_prdata;
  bit          m_pend;

  task automatic model_reset();
    m_x = 0; m_y = 0; m_z = 0; m_ctrl = 32'h0001_0000; m_prdata = 0; m_pend = 0;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [4:0] a);
    return (a % 4 != 0) || (a > 16) || (a == 16 && !LATCH);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (m_err(a)) return 0;
    case (a)
      5'd0:    return xResult;
      5'd4:    return yResult;
      5'd8:    return zResult;
      5'd12:   return m_ctrl;
      default: return {31'b0, m_pend};
    endcase
  endfunction

  task automatic check_state(input string tag);
    chk({tag, ".x"}, xInput, m_x);
    chk({tag, ".y"}, yInput, m_y);
    chk({tag, ".z"}, zInput, m_z);
    chk({tag, ".ctrl"}, controlRegisterInput, m_ctrl);
    chk({tag, ".prdata"}, prdata, m_prdata);
  endtask

  task automatic xfer(input bit w, input logic [4:0] a, input logic [31:0] d,
                      input bit cwe, input logic [31:0] cval, input bit intr,
                      output logic [31:0] rd, output bit err);
    int lat = 0;
    bit got = 0;
    bit e;
    @(negedge clk);
    psel = 1; pwrite = w; paddr = a; pwdata = d; penable = 0;
    @(negedge clk);
    penable = 1;
    for (int i = 0; i < 8 && !got; i++) begin
      @(negedge clk);
      if (i == 0) begin
        controlRegisterWriteEnable = cwe; controlRegisterOutput = cval; interrupt = intr;
      end else begin
        controlRegisterWriteEnable = 0; interrupt = 0;
      end
      if (pready) begin got = 1; lat = i + 1; end
    end
    controlRegisterWriteEnable = 0; interrupt = 0;
    rd = prdata; err = pslverr;
    psel = 0; penable = 0;
    e = m_err(a);
    if (!w) m_prdata = m_read(a);
    if (cwe) m_ctrl = cval;
    if (w && !e) begin
      case (a)
        5'd0:  m_x = d;
        5'd4:  m_y = d;
        5'd8:  m_z = d;
        5'd12: m_ctrl[15:0] = d[15:0];
        default: if (d[0]) m_pend = 0;
      endcase
    end
    if (intr) m_pend = LATCH;
    chk("pready_seen", {31'b0, got}, 1);
    chk("latency", lat, 2);
    chk("pslverr", {31'b0, err}, {31'b0, e});
    check_state("xfer");
  endtask

  typedef struct {
    bit          w;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t        tbl[10];
  logic [31:0] rd;
  bit          er;
  logic [5:0]  pat;

  initial begin
    tbl[0] = '{1, 5'h00, 32'h0000_1234, 0, 32'h0};
    tbl[1] = '{0, 5'h00, 32'h0, 0, 32'hDEAD_BEEF};
    tbl[2] = '{0, 5'h14, 32'h0, 1, 32'h0};
    tbl[3] = '{0, 5'h02, 32'h0, 1, 32'h0};
    tbl[4] = '{1, 5'h06, 32'h5555_5555, 1, 32'h0};
    tbl[5] = '{0, 5'h04, 32'h0, 0, 32'h1357_9BDF};
    tbl[6] = '{0, 5'h08, 32'h0, 0, 32'h2468_ACE0};
    tbl[7] = '{1, 5'h0C, 32'hFFFF_0D05, 0, 32'h0};
    tbl[8] = '{0, 5'h0C, 32'h0, 0, 32'h0001_0D05};
    tbl[9] = '{0, 5'h10, 32'h0, !LATCH, 32'h0};

    model_reset();
    repeat (3) @(negedge clk);
    chk("rst.pready", {31'b0, pready}, 0);
    chk("rst.pslverr", {31'b0, pslverr}, 0);
    chk("rst.irq", {31'b0, irq}, 0);
    check_state("rst");
    chk("rst.ctrl_const", controlRegisterInput, 32'h0001_0000);
    rst = 1;

    // Reset arrives while a write to Y sits in WAIT.
    @(negedge clk); psel = 1; pwrite = 1; paddr = 5'h04; pwdata = 32'hCAFE_0004;
    @(negedge clk); penable = 1;
    @(negedge clk); rst = 0; #1;
    chk("midrst.pready", {31'b0, pready}, 0);
    @(negedge clk); rst = 1; psel = 0; penable = 0;
    @(negedge clk);
    chk("midrst.pready2", {31'b0, pready}, 0);
    chk("midrst.y", yInput, 0);
    chk("midrst.ctrl", controlRegisterInput, 32'h0001_0000);
    @(negedge clk);
    chk("midrst.pready3", {31'b0, pready}, 0);

    xResult = 32'hDEAD_BEEF; yResult = 32'h1357_9BDF; zResult = 32'h2468_ACE0;
    for (int i = 0; i < 10; i++) begin
      xfer(tbl[i].w, tbl[i].addr, tbl[i].data, 0, 0, 0, rd, er);
      chk($sformatf("tbl%0d.err", i), {31'b0, er}, {31'b0, tbl[i].exp_err});
      if (!tbl[i].w) chk($sformatf("tbl%0d.rd", i), rd, tbl[i].exp_rd);
    end
    chk("tbl.x_const", xInput, 32'h0000_1234);

    // Bus write and controller write-back land on the same edge.
    xfer(1, 5'h0C, 32'hFFFF_0D05, 1, 32'h0003_0000, 0, rd, er);
    chk("collide.ctrl", controlRegisterInput, 32'h0003_0D05);

    // psel/penable held high: DONE must return to IDLE before the next start.
    @(negedge clk); psel = 1; pwrite = 0; paddr = 5'h00; penable = 0;
    @(negedge clk); penable = 1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk); pat[i] = pready;
    end
    psel = 0; penable = 0;
    m_prdata = xResult;
    chk("b2b.pattern", {26'b0, pat}, 32'b010010);

    // psel dropped in WAIT: the write still completes.
    @(negedge clk); psel = 1; pwrite = 1; paddr = 5'h08; pwdata = 32'h0BAD_F00D;
    @(negedge clk); penable = 1;
    @(negedge clk); psel = 0; penable = 0;
    @(negedge clk);
    m_z = 32'h0BAD_F00D;
    chk("drop.pready", {31'b0, pready}, 1);
    chk("drop.z", zInput, m_z);

    @(negedge clk);
    chk("irq.idle", {31'b0, irq}, 0);
    interrupt = 1;
    @(negedge clk); interrupt = 0;
    chk("irq.t1", {31'b0, irq}, 1);
    @(negedge clk);
    chk("irq.t2", {31'b0, irq}, {31'b0, LATCH});
    if (LATCH) begin
      m_pend = 1;
      repeat (3) @(negedge clk);
      chk("irq.sticky", {31'b0, irq}, 1);
      xfer(0, 5'h10, 0, 0, 0, 0, rd, er);
      chk("irq.status", rd, 1);
      xfer(1, 5'h10, 32'h1, 0, 0, 0, rd, er);
      chk("irq.cleared", {31'b0, irq}, 0);
      xfer(1, 5'h10, 32'h1, 0, 0, 1, rd, er);
      chk("irq.edge_and_clear", {31'b0, irq}, 1);
      xfer(1, 5'h10, 32'h1, 0, 0, 0, rd, er);
      chk("irq.cleared2", {31'b0, irq}, 0);
    end

    for (int n = 0; n < 200; n++) begin
      logic [4:0] a;
      case ($urandom_range(0, 5))
        0: a = 5'h00;
        1: a = 5'h04;
        2: a = 5'h08;
        3: a = 5'h0C;
        4: a = 5'h10;
        default: a = 5'($urandom_range(0, 31));
      endcase
      xResult = $urandom; yResult = $urandom; zResult = $urandom;
      xfer($urandom_range(0, 1) == 1, a, $urandom, $urandom_range(0, 3) == 0, $urandom, 0, rd, er);
      if ($urandom_range(0, 7) == 0) begin
        @(negedge clk); controlRegisterWriteEnable = 1; controlRegisterOutput = $urandom;
        m_ctrl = controlRegisterOutput;
        @(negedge clk); controlRegisterWriteEnable = 0;
        chk("rand.wb", controlRegisterInput, m_ctrl);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/cordic_bus_slave.md
CORDIC_BUS_SLAVE -- requirements
Module: cordic_bus_slave

Interface
REQ-001 The block SHALL have parameter p_WIDTH, default 32, giving the data width of the CORDIC operands and control register.
REQ-002 The block SHALL have parameter p_ADDR_WIDTH, default 5, giving the byte address width.
REQ-003 The block SHALL have port clk, input, width 1, the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, width 1, asynchronous active-low reset.
REQ-005 The block SHALL have ports psel, penable and pwrite, each input, width 1, carrying APB-style select, enable and write strobes.
REQ-006 The block SHALL have port paddr, input, width p_ADDR_WIDTH, the byte address.
REQ-007 The block SHALL have port pwdata, input, width p_WIDTH, the write data.
REQ-008 The block SHALL have ports prdata (output, p_WIDTH, read data), pready (output, 1, transfer complete) and pslverr (output, 1, transfer error).
REQ-009 The block SHALL have ports xInput, yInput, zInput and controlRegisterInput, each output, width p_WIDTH, driving the CORDIC controller's operand and control inputs.
REQ-010 The block SHALL have ports xResult, yResult, zResult and controlRegisterOutput, each input, width p_WIDTH, carrying controller results and control/flag write-back.
REQ-011 The block SHALL have port controlRegisterWriteEnable, input, width 1, the controller's write-back strobe.
REQ-012 The block SHALL have ports interrupt (input, 1, from the controller) and irq (output, 1, to the host).

Function
REQ-013 Register map SHALL be: 0x00 X (write xInput, read xResult), 0x04 Y, 0x08 Z likewise, 0x0C CONTROL (read/write shadow), 0x10 IRQ_STATUS.
REQ-014 Transfer FSM SHALL have states IDLE, WAIT and DONE; IDLE->WAIT on psel&penable; WAIT->DONE unconditionally; DONE->IDLE unconditionally.
REQ-015 pready SHALL be 1 only in DONE, giving exactly one wait state per transfer; each transfer completes 2 cycles after penable rises.
REQ-016 Writes SHALL commit on the WAIT->DONE edge; read data SHALL be captured into prdata on the same edge and held until the next read completes.
REQ-017 pslverr SHALL be 1 with pready when paddr[1:0]!=0 or paddr>0x10; such writes SHALL have no effect and such reads SHALL return 0.
REQ-018 The CONTROL shadow SHALL drive controlRegisterInput combinationally.
REQ-019 Bits [15:0] of the CONTROL shadow SHALL be written from a bus write; bits [31:16] SHALL be read-only to the bus.
REQ-020 When controlRegisterWriteEnable=1, the whole CONTROL shadow SHALL be loaded from controlRegisterOutput.
REQ-021 On a same-cycle bus write to CONTROL and controller write-back, bits [15:0] SHALL take the bus value and bits [31:16] the controller value.
REQ-022 Deasserting psel mid-transfer SHALL NOT abort it; the FSM SHALL complete through DONE.
REQ-023 A transfer SHALL NOT begin in the DONE cycle; the FSM returns to IDLE first.

Reset
REQ-024 While rst=0, the FSM SHALL be in IDLE; pready, pslverr, prdata, xInput, yInput, zInput and irq SHALL be 0; controlRegisterInput SHALL be 0x0001_0000 (Ready flag set).
REQ-025 Reset asserted mid-transfer SHALL abandon the transfer with no register update.

Configuration
REQ-026 With CORDIC_BUS_IRQ_LATCH_EN defined, a rising edge of interrupt SHALL set a sticky pending bit; irq SHALL equal that bit.
REQ-027 With CORDIC_BUS_IRQ_LATCH_EN defined, IRQ_STATUS bit 0 SHALL read the pending bit, and writing 1 to it SHALL clear it.
REQ-028 With CORDIC_BUS_IRQ_LATCH_EN defined, a same-cycle edge and clear SHALL leave the pending bit set.
REQ-029 Without CORDIC_BUS_IRQ_LATCH_EN, irq SHALL equal interrupt registered by one cycle, and address 0x10 SHALL respond with pslverr=1.

Verification
REQ-030 Write 0x0000_1234 to 0x00 -> pready 2 cycles after penable, pslverr=0, xInput=0x0000_1234 on the following cycle.
REQ-031 With xResult=0xDEAD_BEEF, read 0x00 -> prdata=0xDEAD_BEEF with pready after one wait state.
REQ-032 Write 0xFFFF_0D05 to 0x0C in the same cycle the controller writes 0x0003_0000 with WE=1 -> controlRegisterInput=0x0003_0D05.
REQ-033 Read 0x14 and read 0x02 -> pslverr=1, prdata=0, no state change.
REQ-034 With CORDIC_BUS_IRQ_LATCH_EN, pulse interrupt for 1 cycle -> irq=1 until a write of 0x1 to 0x10, then irq=0.
REQ-035 Assert rst mid-write to 0x04 -> yInput remains 0, FSM in IDLE, controlRegisterInput=0x0001_0000.
